message_stream_arbiter: RTL and testbench
=========================================

// Module: message_stream_arbiter
// PURPOSE
//  Shares one message output stream between N_STREAMS word-serial sources (message slicer outputs).
//  Each source's words are buffered in a per-stream FIFO.
//  Whole packets (header + payload) are granted round-robin, so packets never interleave on the output.
//  Sits between the slicers and the single downstream message sink/debug port.
// PARAMETERS
//  N_STREAMS        2   number of input streams
//  LOG_N_STREAMS    1   clog2(N_STREAMS), min 1
//  WIDTH            32  word width
//  FIFO_LENGTH      16  words per input FIFO (power of 2)
//  LOG_FIFO_LENGTH  4   log2(FIFO_LENGTH)
//  LEN_BITS         8   width of header length field (LEN_BITS < WIDTH)
// PORTS
//  clk           in   1                  clock
//  rst           in   1                  synchronous, active-high reset
//  in_data       in   WIDTH*N_STREAMS    stream i word at [(i+1)*WIDTH-1 -: WIDTH]
//  in_nd         in   N_STREAMS          bit i high = valid word on stream i this cycle (level-per-word)
//  out_data      out  WIDTH              granted word, registered
//  out_nd        out  1                  high for exactly one cycle per output word
//  out_stream    out  LOG_N_STREAMS      index of stream owning current out_data
//  error         out  N_STREAMS          sticky per-stream error flags
// BEHAVIOUR
//  Reset (rst=1 at posedge): FIFOs emptied; FSM to IDLE; rr pointer = N_STREAMS-1 (stream 0 checked first);
//   out_data=0, out_nd=0, out_stream=0, error=0. Reset mid-packet abandons the packet; no partial output follows.
//  Packet format: header word has bit WIDTH-1 = 1; bits LEN_BITS-1:0 = L = payload word count (0..2^LEN_BITS-1).
//   The L following words are payload; their bit WIDTH-1 is not inspected.
//  FIFO write: in_nd[i]=1 and FIFO i not full -> push. If full -> word dropped, error[i] set.
//   Simultaneous push+pop on a full FIFO is accepted (pop frees the slot the same cycle).
//  FSM states:
//   IDLE: scan streams rr+1, rr+2, ... (wrapping) for first non-empty FIFO.
//    - Head is a header: pop it, drive it out (out_nd=1), out_stream=i, rr<=i, cnt<=L.
//      Next state SEND if L>0, else stay IDLE.
//    - Head is not a header: pop and discard (resync), error[i] set, out_nd=0, stay IDLE.
//   SEND: if FIFO[grant] non-empty, pop one word, output it, cnt<=cnt-1; when cnt reaches 0 go IDLE.
//    If FIFO[grant] empty, stall with out_nd=0 and keep grant (no timeout, other streams wait).
//  Throughput: one word/cycle while data available; back-to-back packets from different streams with no gap
//   (IDLE arbitrates and emits the header in the same cycle).
//  Latency: word pushed at edge k can appear at out_data at edge k+1 at the earliest (FIFO read is first-word-fall-through).
//  Counter widths: cnt is LEN_BITS wide; rr/grant are LOG_N_STREAMS wide and wrap at N_STREAMS-1 -> 0 (not 2^LOG).
//  out_data holds its last value when out_nd=0.
// STRUCTURE
//  Shared package/header (message_defs): HDR_FLAG_BIT=WIDTH-1, LEN_BITS, FSM state encodings IDLE=0/SEND=1.
//  Sub-module: message_fifo (single-clock, FWFT, sync active-high rst, full/empty/push/pop), one instance per stream (generate).
//  Top: rr arbiter + FSM + output register.
// TESTING
//  1. Stream0 sends hdr(L=3)+3 words, stream1 idle -> 4 consecutive out_nd cycles, out_stream=0, data in order.
//  2. Both streams load hdr(L=2)+2 words in the same cycle -> stream0 packet (3 words), then stream1 packet (3 words) with no gap;
//     repeating the load -> stream0 granted again only after stream1 (rr).
//  3. Stream1 sends hdr(L=4) + 2 words, pauses 5 cycles, sends 2 words; stream0 has a full packet waiting
//     -> out_nd low 5 cycles, stream1 packet completes, then stream0 starts.
//  4. Stream0 pushes 17 words with FIFO_LENGTH=16 and grant held elsewhere -> error[0]=1, 17th word absent, error stays set.
//  5. Stream0 sends a payload-format word (bit31=0) while IDLE -> word discarded, error[0]=1, following hdr(L=0) emitted alone.
//  6. rst asserted in SEND after 1 of 3 payload words -> next cycle out_nd=0, error=0, FIFOs empty; a new packet afterwards is emitted intact.

Source files
------------

// File: rtl/message_stream_arbiter_pkg.sv
// Shared definitions for the message stream arbiter: FSM states, header layout helpers and
// the default word/length geometry.
package message_stream_arbiter_pkg;

    localparam int unsigned DEFAULT_WIDTH    = 32;
    localparam int unsigned DEFAULT_LEN_BITS = 8;

    typedef enum logic {
        StIdle = 1'b0,
        StSend = 1'b1
    } arb_state_e;

    // Header words are marked by their most significant bit.
    function automatic int unsigned hdr_flag_bit(input int unsigned width);
        return width - 1;
    endfunction

endpackage

// File: rtl/message_fifo.sv
// Single-clock first-word-fall-through FIFO; rdata shows the head word whenever empty is low.
module message_fifo #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned LOG_DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [LOG_DEPTH:0] wr_ptr_q;
    logic [LOG_DEPTH:0] rd_ptr_q;
    logic               wr_en;
    logic               rd_en;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[LOG_DEPTH] != rd_ptr_q[LOG_DEPTH]) &&
                   (wr_ptr_q[LOG_DEPTH-1:0] == rd_ptr_q[LOG_DEPTH-1:0]);
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;
    assign rdata = mem[rd_ptr_q[LOG_DEPTH-1:0]];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (rd_en) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && wr_en) mem[wr_ptr_q[LOG_DEPTH-1:0]] <= wdata;
    end

endmodule

// File: rtl/message_stream_arbiter.sv
// Merges N word-serial message streams onto one output, granting whole packets round-robin
// so that packets never interleave.
module message_stream_arbiter
    import message_stream_arbiter_pkg::*;
#(
    parameter int unsigned N_STREAMS       = 2,
    parameter int unsigned LOG_N_STREAMS   = 1,
    parameter int unsigned WIDTH           = DEFAULT_WIDTH,
    parameter int unsigned FIFO_LENGTH     = 16,
    parameter int unsigned LOG_FIFO_LENGTH = 4,
    parameter int unsigned LEN_BITS        = DEFAULT_LEN_BITS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH*N_STREAMS-1:0] in_data,
    input  logic [N_STREAMS-1:0]       in_nd,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_nd,
    output logic [LOG_N_STREAMS-1:0]   out_stream,
    output logic [N_STREAMS-1:0]       error
);

    localparam int unsigned HDR_BIT = hdr_flag_bit(WIDTH);

    logic [WIDTH-1:0]         fifo_rdata [N_STREAMS];
    logic [N_STREAMS-1:0]     fifo_full;
    logic [N_STREAMS-1:0]     fifo_empty;
    logic [N_STREAMS-1:0]     pop;
    logic [N_STREAMS-1:0]     drop;
    logic [N_STREAMS-1:0]     resync;

    arb_state_e               state_q;
    logic [LOG_N_STREAMS-1:0] rr_q;
    logic [LEN_BITS-1:0]      cnt_q;

    logic                     found;
    logic [LOG_N_STREAMS-1:0] sel;
    logic [LOG_N_STREAMS-1:0] src;
    logic [WIDTH-1:0]         head;

    for (genvar i = 0; i < N_STREAMS; i++) begin : g_fifo
        message_fifo #(
            .WIDTH     (WIDTH),
            .DEPTH     (FIFO_LENGTH),
            .LOG_DEPTH (LOG_FIFO_LENGTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (in_nd[i]),
            .wdata (in_data[(i+1)*WIDTH-1 -: WIDTH]),
            .pop   (pop[i]),
            .rdata (fifo_rdata[i]),
            .full  (fifo_full[i]),
            .empty (fifo_empty[i])
        );
    end

    always_comb begin
        int unsigned idx;
        logic [LOG_N_STREAMS-1:0] cand;
        idx   = 0;
        cand  = '0;
        found = 1'b0;
        sel   = rr_q;
        // Scan starts just after the last granted stream and wraps at N_STREAMS-1.
        for (int unsigned k = 1; k <= N_STREAMS; k++) begin
            idx  = (int'(rr_q) + k) % N_STREAMS;
            cand = LOG_N_STREAMS'(idx);
            if (!found && !fifo_empty[cand]) begin
                found = 1'b1;
                sel   = cand;
            end
        end

        src    = (state_q == StIdle) ? sel : rr_q;
        head   = fifo_rdata[src];
        pop    = '0;
        resync = '0;
        if (state_q == StIdle) begin
            if (found) begin
                pop[sel] = 1'b1;
                if (!head[HDR_BIT]) resync[sel] = 1'b1;
            end
        end else if (!fifo_empty[rr_q]) begin
            pop[rr_q] = 1'b1;
        end
        drop = in_nd & fifo_full & ~pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            rr_q       <= LOG_N_STREAMS'(N_STREAMS - 1);
            cnt_q      <= '0;
            out_data   <= '0;
            out_nd     <= 1'b0;
            out_stream <= '0;
            error      <= '0;
        end else begin
            out_nd <= 1'b0;
            error  <= error | drop | resync;
            case (state_q)
                StIdle: begin
                    if (found && head[HDR_BIT]) begin
                        out_data   <= head;
                        out_nd     <= 1'b1;
                        out_stream <= sel;
                        rr_q       <= sel;
                        cnt_q      <= head[LEN_BITS-1:0];
                        if (head[LEN_BITS-1:0] != '0) state_q <= StSend;
                    end
                end
                StSend: begin
                    if (!fifo_empty[rr_q]) begin
                        out_data   <= head;
                        out_nd     <= 1'b1;
                        out_stream <= rr_q;
                        cnt_q      <= cnt_q - 1'b1;
                        if (cnt_q == LEN_BITS'(1)) state_q <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_message_stream_arbiter.sv
// Self-checking bench: vector table, directed corner sequences and random traffic, all
// compared against a queue-based packet model.
module tb_message_stream_arbiter;

    localparam int N  = 2;
    localparam int W  = 32;
    localparam int FL = 16;

    logic           clk = 1'b0;
    logic           rst;
    logic [W*N-1:0] in_data;
    logic [N-1:0]   in_nd;
    logic [W-1:0]   out_data;
    logic           out_nd;
    logic           out_stream;
    logic [N-1:0]   error;

    always #5 clk = ~clk;

    message_stream_arbiter #(
        .N_STREAMS       (2),
        .LOG_N_STREAMS   (1),
        .WIDTH           (32),
        .FIFO_LENGTH     (16),
        .LOG_FIFO_LENGTH (4),
        .LEN_BITS        (8)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .in_data    (in_data),
        .in_nd      (in_nd),
        .out_data   (out_data),
        .out_nd     (out_nd),
        .out_stream (out_stream),
        .error      (error)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: one queue per stream, a packet owner and a remaining-word count.
    logic [31:0] mq [N][$];
    bit          m_busy;
    int          m_rr;
    int          m_rem;
    logic [31:0] m_data;
    logic        m_nd;
    int          m_stream;
    logic [N-1:0] m_err;

    function automatic void model_reset();
        for (int s = 0; s < N; s++) mq[s].delete();
        m_busy = 0; m_rr = N - 1; m_rem = 0;
        m_data = '0; m_nd = 1'b0; m_stream = 0; m_err = '0;
    endfunction

    function automatic void model_step(input logic r, input logic [N-1:0] nd,
                                       input logic [W*N-1:0] d);
        logic [31:0] w;
        if (r) begin
            model_reset();
            return;
        end
        m_nd = 1'b0;
        if (!m_busy) begin
            for (int k = 1; k <= N; k++) begin
                int s = (m_rr + k) % N;
                if (mq[s].size() != 0) begin
                    w = mq[s].pop_front();
                    if (w[31]) begin
                        m_data = w; m_nd = 1'b1; m_stream = s; m_rr = s;
                        m_rem = int'(w[7:0]);
                        m_busy = (m_rem != 0);
                    end else begin
                        m_err[s] = 1'b1;
                    end
                    break;
                end
            end
        end else if (mq[m_rr].size() != 0) begin
            w = mq[m_rr].pop_front();
            m_data = w; m_nd = 1'b1; m_stream = m_rr;
            m_rem--;
            if (m_rem == 0) m_busy = 0;
        end
        for (int s = 0; s < N; s++) begin
            if (nd[s]) begin
                if (mq[s].size() < FL) mq[s].push_back(d[s*W +: W]);
                else m_err[s] = 1'b1;
            end
        end
    endfunction

    task automatic step(input logic r, input logic [N-1:0] nd, input logic [31:0] d0,
                        input logic [31:0] d1);
        rst = r; in_nd = nd; in_data = {d1, d0};
        @(posedge clk);
        #1;
        model_step(r, nd, {d1, d0});
        check("model.out_nd", 32'(out_nd), 32'(m_nd));
        check("model.out_stream", 32'(out_stream), 32'(m_stream));
        check("model.out_data", out_data, m_data);
        check("model.error", 32'(error), 32'(m_err));
    endtask

    typedef struct {
        logic        r;
        logic [1:0]  nd;
        logic [31:0] d0;
        logic [31:0] d1;
        logic        e_nd;
        logic        e_s;
        logic [31:0] e_d;
    } vec_t;

    vec_t tbl [$];

    function automatic void add(input logic r, input logic [1:0] nd, input logic [31:0] d0,
                                input logic [31:0] d1, input logic e_nd, input logic e_s,
                                input logic [31:0] e_d);
        vec_t v;
        v.r = r; v.nd = nd; v.d0 = d0; v.d1 = d1; v.e_nd = e_nd; v.e_s = e_s; v.e_d = e_d;
        tbl.push_back(v);
    endfunction

    logic [N-1:0] rnd_nd;
    logic [31:0]  rnd_d [N];
    logic [31:0]  gen [N][$];
    int           cnt_s0;
    logic [31:0]  last_s0;

    initial begin
        rst = 1'b1; in_nd = '0; in_data = '0;
        model_reset();

        // Single stream packet, then two streams loaded together (twice).
        add(1, 2'b00, 0, 0, 0, 0, 32'h0);
        add(0, 2'b01, 32'h8000_0003, 0, 0, 0, 32'h0);
        add(0, 2'b01, 32'h1111_0001, 0, 1, 0, 32'h8000_0003);
        add(0, 2'b01, 32'hA5A5_0002, 0, 1, 0, 32'h1111_0001);
        add(0, 2'b01, 32'h1111_0003, 0, 1, 0, 32'hA5A5_0002);
        add(0, 2'b00, 0, 0, 1, 0, 32'h1111_0003);
        add(0, 2'b00, 0, 0, 0, 0, 32'h1111_0003);
        add(1, 2'b00, 0, 0, 0, 0, 32'h0);
        add(0, 2'b11, 32'h8000_0002, 32'h8ABC_0002, 0, 0, 32'h0);
        add(0, 2'b11, 32'h0B00_0000, 32'h0C00_0000, 1, 0, 32'h8000_0002);
        add(0, 2'b11, 32'h0B00_0001, 32'h0C00_0001, 1, 0, 32'h0B00_0000);
        add(0, 2'b00, 0, 0, 1, 0, 32'h0B00_0001);
        add(0, 2'b11, 32'h8001_0002, 32'h8ABD_0002, 1, 1, 32'h8ABC_0002);
        add(0, 2'b11, 32'h0B00_0002, 32'h0C00_0002, 1, 1, 32'h0C00_0000);
        add(0, 2'b11, 32'h0B00_0003, 32'h0C00_0003, 1, 1, 32'h0C00_0001);
        add(0, 2'b00, 0, 0, 1, 0, 32'h8001_0002);
        add(0, 2'b00, 0, 0, 1, 0, 32'h0B00_0002);
        add(0, 2'b00, 0, 0, 1, 0, 32'h0B00_0003);
        add(0, 2'b00, 0, 0, 1, 1, 32'h8ABD_0002);
        add(0, 2'b00, 0, 0, 1, 1, 32'h0C00_0002);
        add(0, 2'b00, 0, 0, 1, 1, 32'h0C00_0003);
        add(0, 2'b00, 0, 0, 0, 1, 32'h0C00_0003);

        foreach (tbl[i]) begin
            step(tbl[i].r, tbl[i].nd, tbl[i].d0, tbl[i].d1);
            check($sformatf("tbl[%0d].out_nd", i), 32'(out_nd), 32'(tbl[i].e_nd));
            check($sformatf("tbl[%0d].out_stream", i), 32'(out_stream), 32'(tbl[i].e_s));
            check($sformatf("tbl[%0d].out_data", i), out_data, tbl[i].e_d);
        end

        // Stalled stream1 packet holds the grant while stream0 waits.
        step(1, 2'b00, 0, 0);
        step(0, 2'b10, 0, 32'h8000_0004);
        step(0, 2'b11, 32'h8000_0001, 32'h2200_0000);
        check("stall.hdr_stream", 32'(out_stream), 32'd1);
        step(0, 2'b11, 32'h3300_0000, 32'h2200_0001);
        step(0, 2'b00, 0, 0);
        check("stall.p1", out_data, 32'h2200_0001);
        for (int i = 0; i < 4; i++) begin
            step(0, 2'b00, 0, 0);
            check("stall.gap", 32'(out_nd), 32'd0);
        end
        step(0, 2'b10, 0, 32'h2200_0002);
        check("stall.gap5", 32'(out_nd), 32'd0);
        step(0, 2'b10, 0, 32'h2200_0003);
        check("stall.p2", out_data, 32'h2200_0002);
        step(0, 2'b00, 0, 0);
        step(0, 2'b00, 0, 0);
        check("stall.s0_after", 32'(out_stream), 32'd0);
        check("stall.s0_hdr", out_data, 32'h8000_0001);
        step(0, 2'b00, 0, 0);
        step(0, 2'b00, 0, 0);

        // Overflow of stream0 while stream1 owns the output.
        step(1, 2'b00, 0, 0);
        step(0, 2'b10, 0, 32'h8000_0005);
        for (int i = 0; i < 17; i++) begin
            step(0, 2'b01, (i == 0) ? 32'h8000_000F : (i == 16) ? 32'h8000_EE00 :
                 32'h0400_0000 + 32'(i), 0);
        end
        check("ovf.error", 32'(error), 32'h1);
        for (int i = 0; i < 5; i++) step(0, 2'b10, 0, 32'h5500_0000 + 32'(i));
        cnt_s0 = 0;
        last_s0 = '0;
        for (int i = 0; i < 24; i++) begin
            step(0, 2'b00, 0, 0);
            if (out_nd && out_stream == 1'b0) begin
                cnt_s0++;
                last_s0 = out_data;
            end
        end
        check("ovf.s0_words", 32'(cnt_s0), 32'd16);
        check("ovf.s0_last", last_s0, 32'h0400_000F);
        check("ovf.error_sticky", 32'(error), 32'h1);

        // Non-header at the head of an idle stream is discarded.
        step(1, 2'b00, 0, 0);
        step(0, 2'b01, 32'h0000_1234, 0);
        step(0, 2'b01, 32'h8000_AB00, 0);
        check("resync.nd", 32'(out_nd), 32'd0);
        check("resync.error", 32'(error), 32'h1);
        step(0, 2'b00, 0, 0);
        check("resync.hdr", out_data, 32'h8000_AB00);
        check("resync.hdr_nd", 32'(out_nd), 32'd1);
        step(0, 2'b00, 0, 0);
        check("resync.alone", 32'(out_nd), 32'd0);

        // Reset in the middle of a packet.
        step(1, 2'b00, 0, 0);
        step(0, 2'b01, 32'h8000_0003, 0);
        step(0, 2'b01, 32'h6600_0000, 0);
        step(0, 2'b01, 32'h6600_0001, 0);
        check("rst.r0", out_data, 32'h6600_0000);
        step(1, 2'b00, 0, 0);
        check("rst.nd", 32'(out_nd), 32'd0);
        check("rst.error", 32'(error), 32'd0);
        step(0, 2'b00, 0, 0);
        check("rst.empty_nd", 32'(out_nd), 32'd0);
        check("rst.empty_err", 32'(error), 32'd0);
        step(0, 2'b01, 32'h8000_0001, 0);
        step(0, 2'b01, 32'h7700_0000, 0);
        check("rst.new_hdr", out_data, 32'h8000_0001);
        step(0, 2'b00, 0, 0);
        check("rst.new_payload", out_data, 32'h7700_0000);
        step(0, 2'b00, 0, 0);
        check("rst.new_end", 32'(out_nd), 32'd0);

        // Random traffic against the model, alternating busy and quiet phases.
        step(1, 2'b00, 0, 0);
        for (int cyc = 0; cyc < 4000; cyc++) begin
            for (int s = 0; s < N; s++) begin
                if (gen[s].size() == 0) begin
                    if ($urandom_range(0, 11) == 0) begin
                        gen[s].push_back($urandom & 32'h7FFF_FFFF);
                    end else begin
                        int len = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 40)
                                                              : $urandom_range(0, 5);
                        gen[s].push_back(32'h8000_0000 | ($urandom & 32'h7FFF_FF00) |
                                         32'(len));
                        for (int j = 0; j < len; j++) gen[s].push_back($urandom);
                    end
                end
                rnd_nd[s] = ((cyc / 256) % 2 == 0) ? ($urandom_range(0, 3) != 0)
                                                   : ($urandom_range(0, 3) == 0);
                rnd_d[s]  = rnd_nd[s] ? gen[s].pop_front() : $urandom;
            end
            step(($urandom_range(0, 999) == 0), rnd_nd, rnd_d[0], rnd_d[1]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
